tap_controller: RTL and testbench

IEEE 1149.1 TAP state machine for the JTAG block. Advances a 16-state FSM on `tck` from `tms`. Drives the instruction-register stage through `clkIR`, `shIR`, `upIR` and the 4-bit `state` bus, and drives the data-register stages through the matching DR controls. It sits directly upstream of the instruction register and the boundary/bypass/IDCODE data registers.

---
 rtl/tap_controller_pkg.sv | 72 +++++++
 rtl/tap_controller.sv | 92 +++++++++
 tb/tb_tap_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_controller_pkg.sv
// Shared types and helpers for the IEEE 1149.1 TAP controller.
// Holds the 16-state encoding and the decode from state to the registered controls.
package tap_controller_pkg;

  // The code values are the standard 1149.1 encoding, which the rest of the JTAG block relies on.
  typedef enum logic [3:0] {
    EX2DR_C = 4'h0,
    EX1DR_C = 4'h1,
    SHDR_C  = 4'h2,
    PADR_C  = 4'h3,
    SELIR_C = 4'h4,
    UPDR_C  = 4'h5,
    CAPDR_C = 4'h6,
    SELDR_C = 4'h7,
    EX2IR_C = 4'h8,
    EX1IR_C = 4'h9,
    SHIR_C  = 4'hA,
    PAIR_C  = 4'hB,
    RTI_C   = 4'hC,
    UPIR_C  = 4'hD,
    CAPIR_C = 4'hE,
    TLR_C   = 4'hF
  } tap_state_e;

  // All the controls that are registered on falling tck, including the two clock-gate enables.
  typedef struct packed {
    logic en_ir;   // gate enable for clkIR
    logic en_dr;   // gate enable for clkDR
    logic sh_ir;
    logic up_ir;
    logic sh_dr;
    logic up_dr;
    logic sel;     // IR column, steers the TDO mux
    logic tdo_en;
    logic tlr;
  } tap_ctrl_t;

  // Value held while reset is asserted: everything low except the test-logic-reset flag.
  localparam tap_ctrl_t CTRL_RESET = '{
    en_ir:  1'b0,
    en_dr:  1'b0,
    sh_ir:  1'b0,
    up_ir:  1'b0,
    sh_dr:  1'b0,
    up_dr:  1'b0,
    sel:    1'b0,
    tdo_en: 1'b0,
    tlr:    1'b1
  };

  // True for every state from SELECT_IR down to UPDATE_IR.
  function automatic logic in_ir_column(input tap_state_e s);
    return s inside {SELIR_C, CAPIR_C, SHIR_C, EX1IR_C, PAIR_C, EX2IR_C, UPIR_C};
  endfunction

  // Pure decode of the current state into the control word.
  function automatic tap_ctrl_t decode_ctrl(input tap_state_e s);
    tap_ctrl_t c;
    c        = '0;
    c.en_ir  = (s == CAPIR_C) || (s == SHIR_C);
    c.en_dr  = (s == CAPDR_C) || (s == SHDR_C);
    c.sh_ir  = (s == SHIR_C);
    c.up_ir  = (s == UPIR_C);
    c.sh_dr  = (s == SHDR_C);
    c.up_dr  = (s == UPDR_C);
    c.sel    = in_ir_column(s);
    c.tdo_en = (s == SHIR_C) || (s == SHDR_C);
    c.tlr    = (s == TLR_C);
    return c;
  endfunction

endpackage

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine.
// The state advances on rising tck from tms; the decoded controls and clock-gate
// enables are re-registered on falling tck so they lag the state by half a cycle
// and the gated clocks clkIR/clkDR cannot glitch.
module tap_controller
  import tap_controller_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output logic [3:0] state,
  output logic       clkIR,
  output logic       shIR,
  output logic       upIR,
  output logic       clkDR,
  output logic       shDR,
  output logic       upDR,
  output logic       select,
  output logic       tdo_en,
  output logic       tlr
);

  tap_state_e state_q, state_d;
  tap_ctrl_t  ctrl_q, ctrl_d;

  // State register: rising tck, reset forces TEST_LOGIC_RESET at once.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      state_q <= TLR_C;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the 1149.1 transition table, tms=0 / tms=1 per state.
  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = TLR_C;
    case (state_q)
      TLR_C:   state_d = tms ? TLR_C   : RTI_C;
      RTI_C:   state_d = tms ? SELDR_C : RTI_C;
      SELDR_C: state_d = tms ? SELIR_C : CAPDR_C;
      SELIR_C: state_d = tms ? TLR_C   : CAPIR_C;
      // Data-register column
      CAPDR_C: state_d = tms ? EX1DR_C : SHDR_C;
      SHDR_C:  state_d = tms ? EX1DR_C : SHDR_C;
      EX1DR_C: state_d = tms ? UPDR_C  : PADR_C;
      PADR_C:  state_d = tms ? EX2DR_C : PADR_C;
      EX2DR_C: state_d = tms ? UPDR_C  : SHDR_C;
      UPDR_C:  state_d = tms ? SELDR_C : RTI_C;
      // Instruction-register column
      CAPIR_C: state_d = tms ? EX1IR_C : SHIR_C;
      SHIR_C:  state_d = tms ? EX1IR_C : SHIR_C;
      EX1IR_C: state_d = tms ? UPIR_C  : PAIR_C;
      PAIR_C:  state_d = tms ? EX2IR_C : PAIR_C;
      EX2IR_C: state_d = tms ? UPIR_C  : SHIR_C;
      UPIR_C:  state_d = tms ? SELDR_C : RTI_C;
      // Any code outside the table recovers through TEST_LOGIC_RESET.
      default: state_d = TLR_C;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    ctrl_d = decode_ctrl(state_q);
  end

  // Control/enable register on falling tck: half-cycle lag behind the state,
  // and the gate enables only change while tck is low.
  always_ff @(negedge tck or posedge reset) begin
    if (reset) begin
      ctrl_q <= CTRL_RESET;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // Gated clocks: enables are stable whenever tck is high, so these are glitch-free.
  assign clkIR  = tck & ctrl_q.en_ir;
  assign clkDR  = tck & ctrl_q.en_dr;

  assign state  = state_q;
  assign shIR   = ctrl_q.sh_ir;
  assign upIR   = ctrl_q.up_ir;
  assign shDR   = ctrl_q.sh_dr;
  assign upDR   = ctrl_q.up_dr;
  assign select = ctrl_q.sel;
  assign tdo_en = ctrl_q.tdo_en;
  assign tlr    = ctrl_q.tlr;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: table-driven IR/DR walks, reset abort,
// five-ones recovery from every state, and a long random tms run against a
// table-lookup reference model of the 1149.1 state graph.
module tb_tap_controller;

  logic       tck = 1'b0;
  logic       reset;
  logic       tms;
  logic [3:0] state;
  logic       clkIR, shIR, upIR, clkDR, shDR, upDR, select, tdo_en, tlr;

  int checks = 0;
  int errors = 0;

  // Reference transition graph: tbl[state][tms] -> next state.
  logic [3:0] tbl [16][2];
  logic [3:0] m_state;

  // Edge counters on the DUT outputs.
  int ir_edges = 0, dr_edges = 0, upir_edges = 0, updr_edges = 0;

  typedef struct {
    logic       tms;
    logic [3:0] st;
  } vec_t;

  tap_controller dut (
    .tck    (tck),
    .reset  (reset),
    .tms    (tms),
    .state  (state),
    .clkIR  (clkIR),
    .shIR   (shIR),
    .upIR   (upIR),
    .clkDR  (clkDR),
    .shDR   (shDR),
    .upDR   (upDR),
    .select (select),
    .tdo_en (tdo_en),
    .tlr    (tlr)
  );

  always #5 tck = ~tck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // {shIR, upIR, shDR, upDR, select, tdo_en, tlr} expected while the given state is decoded.
  function automatic logic [6:0] exp_ctrl(input logic [3:0] s);
    logic ir_col;
    ir_col = (s == 4'h4) || (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
             (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
    return {s == 4'hA, s == 4'hD, s == 4'h2, s == 4'h5, ir_col,
            (s == 4'hA) || (s == 4'h2), s == 4'hF};
  endfunction

  always @(posedge clkIR) begin
    ir_edges++;
    // A gated edge must be a capture or a shift.
    check("clkIR_pulse_without_shift", {31'd0, shIR || (m_state == 4'hE)}, 32'd1);
  end
  always @(posedge clkDR) begin
    dr_edges++;
    check("clkDR_pulse_without_shift", {31'd0, shDR || (m_state == 4'h6)}, 32'd1);
  end
  always @(posedge upIR) upir_edges++;
  always @(posedge upDR) updr_edges++;

  // One tck period: drive tms while tck is low, check state after the rising edge
  // and the lagging controls after the falling edge.
  task automatic step(input logic t);
    logic [3:0] prev;
    int ir0, dr0;
    tms  = t;
    prev = m_state;
    ir0  = ir_edges;
    dr0  = dr_edges;
    @(posedge tck);
    #1;
    m_state = reset ? 4'hF : tbl[prev][t];
    check("state", {28'd0, state}, {28'd0, m_state});
    // Controls still describe the state that was just left.
    check("ctrl_lag", {25'd0, shIR, upIR, shDR, upDR, select, tdo_en, tlr},
          {25'd0, exp_ctrl(prev)});
    check("clkIR_edges", ir_edges - ir0, ((prev == 4'hE) || (prev == 4'hA)) ? 1 : 0);
    check("clkDR_edges", dr_edges - dr0, ((prev == 4'h6) || (prev == 4'h2)) ? 1 : 0);
    @(negedge tck);
    #1;
    check("ctrl", {25'd0, shIR, upIR, shDR, upDR, select, tdo_en, tlr},
          {25'd0, exp_ctrl(m_state)});
  endtask

  // Pulse reset while tck is low and check its asynchronous effect.
  task automatic reset_dut();
    reset = 1'b1;
    #1;
    m_state = 4'hF;
    check("reset_state", {28'd0, state}, 32'hF);
    check("reset_ctrl", {25'd0, shIR, upIR, shDR, upDR, select, tdo_en, tlr},
          {25'd0, 7'b0000001});
    #1;
    reset = 1'b0;
  endtask

  task automatic run_vectors(input vec_t v[$], input string tag);
    foreach (v[i]) begin
      step(v[i].tms);
      check(tag, {28'd0, state}, {28'd0, v[i].st});
    end
  endtask

  // Reach every state by a shortest tms path from TLR, then five tms=1 clocks.
  task automatic five_ones_test();
    int   par[16];
    logic pb[16];
    bit   seen[16];
    int   q[$];
    int   s, n, c;
    logic path[$];
    foreach (seen[i]) seen[i] = 1'b0;
    seen[15] = 1'b1;
    q.push_back(15);
    while (q.size() > 0) begin
      s = q.pop_front();
      for (int b = 0; b < 2; b++) begin
        n = int'(tbl[s][b]);
        if (!seen[n]) begin
          seen[n] = 1'b1;
          par[n]  = s;
          pb[n]   = (b == 1);
          q.push_back(n);
        end
      end
    end
    for (int target = 0; target < 16; target++) begin
      path.delete();
      c = target;
      while (c != 15) begin
        path.push_front(pb[c]);
        c = par[c];
      end
      reset_dut();
      foreach (path[i]) step(path[i]);
      check("reach_state", {28'd0, state}, target);
      repeat (5) step(1'b1);
      check("five_ones_to_tlr", {28'd0, state}, 32'hF);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ir_vec[$];
    vec_t dr_vec[$];
    vec_t sh_vec[$];
    int   u0;

    // 1149.1 transition table, {tms=0, tms=1}.
    tbl[4'hF] = '{4'hC, 4'hF};
    tbl[4'hC] = '{4'hC, 4'h7};
    tbl[4'h7] = '{4'h6, 4'h4};
    tbl[4'h4] = '{4'hE, 4'hF};
    tbl[4'h6] = '{4'h2, 4'h1};
    tbl[4'h2] = '{4'h2, 4'h1};
    tbl[4'h1] = '{4'h3, 4'h5};
    tbl[4'h3] = '{4'h3, 4'h0};
    tbl[4'h0] = '{4'h2, 4'h5};
    tbl[4'h5] = '{4'hC, 4'h7};
    tbl[4'hE] = '{4'hA, 4'h9};
    tbl[4'hA] = '{4'hA, 4'h9};
    tbl[4'h9] = '{4'hB, 4'hD};
    tbl[4'hB] = '{4'hB, 4'h8};
    tbl[4'h8] = '{4'hA, 4'hD};
    tbl[4'hD] = '{4'hC, 4'h7};

    // IR walk: into SHIFT_IR, three tck periods there, then EXIT1 and UPDATE, then RTI.
    ir_vec = '{'{1'b0, 4'hC}, '{1'b1, 4'h7}, '{1'b1, 4'h4}, '{1'b0, 4'hE},
               '{1'b0, 4'hA}, '{1'b0, 4'hA}, '{1'b0, 4'hA}, '{1'b1, 4'h9},
               '{1'b1, 4'hD}, '{1'b0, 4'hC}};
    dr_vec = '{'{1'b0, 4'hC}, '{1'b1, 4'h7}, '{1'b0, 4'h6}, '{1'b0, 4'h2},
               '{1'b1, 4'h1}, '{1'b0, 4'h3}, '{1'b1, 4'h0}, '{1'b1, 4'h5},
               '{1'b0, 4'hC}};
    sh_vec = '{'{1'b0, 4'hC}, '{1'b1, 4'h7}, '{1'b0, 4'h6}, '{1'b0, 4'h2}};

    tms = 1'b1;
    reset_dut();

    // IR path: capture + 3 shifts gives 4 clkIR edges, one UPDATE_IR pulse.
    ir_edges = 0; upir_edges = 0;
    run_vectors(ir_vec, "ir_walk");
    check("ir_clk_count", ir_edges, 4);
    check("ir_update_pulses", upir_edges, 1);

    // DR path: capture + 1 shift, one UPDATE_DR pulse.
    reset_dut();
    dr_edges = 0; updr_edges = 0;
    run_vectors(dr_vec, "dr_walk");
    check("dr_clk_count", dr_edges, 2);
    check("dr_update_pulses", updr_edges, 1);

    // Reset in SHIFT_DR aborts the shift with no UPDATE pulse.
    reset_dut();
    run_vectors(sh_vec, "to_shdr");
    check("in_shdr_shDR", {31'd0, shDR}, 32'd1);
    u0 = updr_edges;
    reset = 1'b1;
    #1;
    m_state = 4'hF;
    check("abort_state", {28'd0, state}, 32'hF);
    check("abort_tlr", {31'd0, tlr}, 32'd1);
    check("abort_shDR", {31'd0, shDR}, 32'd0);
    step(1'b1);
    step(1'b1);
    check("abort_hold", {28'd0, state}, 32'hF);
    reset = 1'b0;
    step(1'b0);
    check("after_release", {28'd0, state}, 32'hC);
    check("abort_no_update", updr_edges - u0, 0);

    five_ones_test();

    // Long random run against the reference graph.
    reset_dut();
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
